// File: rtl/seg_msg_pkg.sv
// seg_msg_pkg: character codes, FSM states and segment encoding for seg_msg_scroller
package seg_msg_pkg;
  typedef logic [4:0] msg_char_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_SCROLLING} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam msg_char_t CH_DASH = 5'h1E;
  localparam msg_char_t CH_BLANK = 5'h1F;
  function automatic logic [7:0] char_to_seg(input msg_char_t c);
    case (c)
      5'h00: char_to_seg = 8'hC0;
      5'h01: char_to_seg = 8'hF9;
      5'h02: char_to_seg = 8'hA4;
      5'h03: char_to_seg = 8'hB0;
      5'h04: char_to_seg = 8'h99;
      5'h05: char_to_seg = 8'h92;
      5'h06: char_to_seg = 8'h82;
      5'h07: char_to_seg = 8'hF8;
      5'h08: char_to_seg = 8'h80;
      5'h09: char_to_seg = 8'h90;
      5'h0A: char_to_seg = 8'h88;
      5'h0B: char_to_seg = 8'h83;
      5'h0C: char_to_seg = 8'hC6;
      5'h0D: char_to_seg = 8'hA1;
      5'h0E: char_to_seg = 8'h86;
      5'h0F: char_to_seg = 8'h8E;
      5'h10: char_to_seg = 8'hC7;
      5'h11: char_to_seg = 8'hAB;
      5'h12: char_to_seg = 8'h8C;
      5'h13: char_to_seg = 8'hAF;
      5'h14: char_to_seg = 8'h92;
      5'h15: char_to_seg = 8'hC1;
      5'h16: char_to_seg = 8'h91;
      5'h17: char_to_seg = 8'h89;
      CH_DASH: char_to_seg = SEG_DASH;
      default: char_to_seg = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: one-cycle enable pulse every DIV enabled cycles
// Ports: clk, rst_n (async active-low), en (count permit, low freezes),
//        restart (hold counter at 0), tick (step pulse, combinational)
module scroll_tick_gen #(
  parameter int unsigned DIV = 30000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && !restart && cnt_q == CW'(DIV - 1);
    cnt_d = (restart || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: loads a character message and scrolls a 4-digit segment window over it
// Ports: basys_clock, rst_n (async active-low); msg_valid/msg_ready/msg_char/msg_last load
//        handshake; clear drops the message; scroll_en permits steps; win_seg 4 active-low
//        digits (leftmost in [31:24]); win_valid; scroll_wrap pulses when offset wraps.
// Option: define SCROLL_DIR_EN to add scroll_left (0 = scroll backwards).
module seg_msg_scroller
  import seg_msg_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned SCROLL_DIV = 30000000
) (
  input  logic        basys_clock,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  msg_char_t   msg_char,
  input  logic        msg_last,
  input  logic        clear,
  input  logic        scroll_en,
`ifdef SCROLL_DIR_EN
  input  logic        scroll_left,
`endif
  output logic [31:0] win_seg,
  output logic        win_valid,
  output logic        scroll_wrap
);
  localparam int W = $clog2(MAX_LEN) + 1;
  localparam int AW = $clog2(MAX_LEN);
  state_t state_q, state_d;
  logic [W-1:0] len_q, len_d, off_q, off_d;
  msg_char_t mem_q [MAX_LEN];
  logic [31:0] win_d;
  logic scrolling, accept, last, tick, dir_left, at_end, at_start, wrap_d;
`ifdef SCROLL_DIR_EN
  assign dir_left = scroll_left;
`else
  assign dir_left = 1'b1;
`endif
  // (offset + i) mod len by repeated compare-and-subtract; three passes cover len = 1
  function automatic logic [AW-1:0] wrap_idx(input logic [W:0] v, input logic [W:0] n);
    logic [W:0] r;
    r = v;
    for (int k = 0; k < 3; k++) r = (r >= n) ? r - n : r;
    return r[AW-1:0];
  endfunction
  assign scrolling = state_q == ST_SCROLLING;
  assign msg_ready = !scrolling;
  assign accept = msg_valid && msg_ready && !clear;
  assign last = msg_last || len_q == W'(MAX_LEN - 1);
  scroll_tick_gen #(.DIV(SCROLL_DIV)) u_tick (
    .clk(basys_clock),
    .rst_n(rst_n),
    .en(scroll_en && scrolling),
    .restart(!scrolling || clear),
    .tick(tick)
  );
  always_comb begin
    state_d = clear ? ST_EMPTY : accept ? (last ? ST_SCROLLING : ST_LOADING) : state_q;
    len_d = clear ? '0 : accept ? len_q + 1'b1 : len_q;
    at_end = off_q == len_q - 1'b1;
    at_start = off_q == '0;
    off_d = (!scrolling || clear) ? '0 : !tick ? off_q :
            dir_left ? (at_end ? '0 : off_q + 1'b1) : (at_start ? len_q - 1'b1 : off_q - 1'b1);
    wrap_d = scrolling && !clear && tick &&
             (dir_left ? at_end : (off_q == W'(1) || len_q == W'(1)));
    win_d = {4{SEG_BLANK}};
    if (scrolling && !clear)
      for (int i = 0; i < 4; i++)
        win_d[31-8*i -: 8] = char_to_seg(mem_q[wrap_idx((W+1)'(off_q) + (W+1)'(i), (W+1)'(len_q))]);
  end
  always_ff @(posedge basys_clock)
    if (accept) mem_q[len_q[AW-1:0]] <= msg_char;
  always_ff @(posedge basys_clock or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      len_q <= '0;
      off_q <= '0;
      win_seg <= {4{SEG_BLANK}};
      win_valid <= 1'b0;
      scroll_wrap <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      off_q <= off_d;
      win_seg <= win_d;
      win_valid <= scrolling && !clear;
      scroll_wrap <= wrap_d;
    end
endmodule

// File: tb/tb_seg_msg_scroller.sv
// tb_seg_msg_scroller: randomized scoreboard bench for seg_msg_scroller
module tb_seg_msg_scroller;
  localparam int DIV = 4;
  localparam int ML = 16;
  logic clk = 0;
  logic rst_n = 0;
  logic msg_valid = 0;
  logic msg_last = 0;
  logic clear = 0;
  logic scroll_en = 0;
  logic [4:0] msg_char = '0;
  logic msg_ready, win_valid, scroll_wrap;
  logic [31:0] win_seg;
  int total = 0;
  int bad = 0;
  int wrap_cnt = 0;
  int exp_wraps = 0;
  int moff = 0;
  int m[$];
  logic [32:0] exp_q[$];
  logic [32:0] e_mon;
  logic prev_valid = 0;
  logic wrap_seen = 0;
  logic [31:0] prev_seg = '1;
  int pool[24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 22, 23, 30};

  always #5 clk = ~clk;

  seg_msg_scroller #(.MAX_LEN(ML), .SCROLL_DIV(DIV)) dut (
    .basys_clock(clk),
    .rst_n(rst_n),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_char(msg_char),
    .msg_last(msg_last),
    .clear(clear),
    .scroll_en(scroll_en),
    .win_seg(win_seg),
    .win_valid(win_valid),
    .scroll_wrap(scroll_wrap)
  );

  function automatic logic [7:0] seg_of(input int c);
    case (c)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
      16: return 8'hC7; 17: return 8'hAB; 18: return 8'h8C; 19: return 8'hAF;
      20: return 8'h92; 21: return 8'hC1; 22: return 8'h91; 23: return 8'h89;
      30: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] win_of(input int off);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = seg_of(m[(off + i) % m.size()]);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (scroll_wrap === 1'b1) begin
      wrap_cnt++;
      wrap_seen = 1;
    end
    if (win_valid === 1'b1 && (!prev_valid || win_seg !== prev_seg)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL window_unexpected got=%h wrap=%b want=none", win_seg, wrap_seen);
      end else begin
        e_mon = exp_q.pop_front();
        if ({wrap_seen, win_seg} !== e_mon) begin
          bad++;
          $display("FAIL window got=%h wrap=%b want=%h wrap=%b", win_seg, wrap_seen, e_mon[31:0], e_mon[32]);
        end
      end
      wrap_seen = 0;
    end
    if (win_valid !== 1'b1) wrap_seen = 0;
    prev_valid = win_valid;
    prev_seg = win_seg;
  end

  task automatic gen(input int n);
    int c;
    m.delete();
    for (int i = 0; i < n; i++) begin
      do c = pool[$urandom_range(0, 23)];
      while ((i > 0 && c == m[i-1]) || (i == n - 1 && n > 1 && c == m[0]));
      m.push_back(c);
    end
  endtask

  task automatic load(input bit mark);
    int n;
    n = m.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        msg_valid = 0;
        @(negedge clk);
      end
      msg_valid = 1;
      msg_char = 5'(m[i]);
      msg_last = mark && i == n - 1;
    end
    @(negedge clk);
    msg_valid = 0;
    msg_last = 0;
    chk1("ready_after_load", msg_ready, 1'b0);
    chk1("valid_lat1", win_valid, 1'b0);
    moff = 0;
    exp_q.push_back({1'b0, win_of(0)});
    @(negedge clk);
    chk1("valid_lat2", win_valid, 1'b1);
    chk("first_win", win_seg, win_of(0));
  endtask

  task automatic scroll(input int k);
    @(negedge clk);
    scroll_en = 1;
    for (int j = 0; j < k; j++) begin
      moff = (moff + 1) % m.size();
      if (moff == 0) exp_wraps++;
      exp_q.push_back({moff == 0, win_of(moff)});
    end
    repeat (k * DIV) @(posedge clk);
    @(negedge clk);
    scroll_en = 0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk1("clr_valid", win_valid, 1'b0);
    chk("clr_seg", win_seg, 32'hFFFFFFFF);
    chk1("clr_ready", msg_ready, 1'b1);
    m.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold;
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_seg", win_seg, 32'hFFFFFFFF);
    chk1("rst_valid", win_valid, 1'b0);
    chk1("rst_wrap", scroll_wrap, 1'b0);
    chk1("rst_ready", msg_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk1("post_rst_ready", msg_ready, 1'b1);
    m = '{30, 16, 0, 20, 14};
    load(1);
    chk("lose_win", win_seg, 32'hBFC7C092);
    w0 = wrap_cnt;
    scroll(5);
    chk("lose_back", win_seg, 32'hBFC7C092);
    chk("lose_wraps", 32'(wrap_cnt - w0), 32'd1);
    @(negedge clk);
    scroll_en = 1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_seg", win_seg, 32'hFFFFFFFF);
    chk1("arst_valid", win_valid, 1'b0);
    chk1("arst_ready", msg_ready, 1'b1);
    scroll_en = 0;
    m.delete();
    @(negedge clk);
    rst_n = 1;
    m = '{14, 20};
    load(1);
    chk("es_win", win_seg, 32'h86928692);
    hold = win_seg;
    w0 = wrap_cnt;
    repeat (20) @(negedge clk);
    chk("es_hold", win_seg, hold);
    chk("es_nowrap", 32'(wrap_cnt - w0), 32'd0);
    scroll(3);
    chk("es_after", win_seg, 32'h92869286);
    do_clear();
    m = '{25, 0};
    load(1);
    chk("unused_win", win_seg, 32'hFFC0FFC0);
    do_clear();
    gen(ML);
    load(0);
    @(negedge clk);
    msg_valid = 1;
    msg_char = 5'h08;
    msg_last = 1;
    repeat (3) begin
      @(negedge clk);
      chk1("full_ready", msg_ready, 1'b0);
    end
    msg_valid = 0;
    msg_last = 0;
    scroll(ML);
    chk("full_wrap_back", win_seg, win_of(0));
    do_clear();
    gen(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      msg_valid = 1;
      msg_char = 5'(m[i]);
    end
    @(negedge clk);
    clear = 1;
    msg_char = 5'h08;
    msg_last = 1;
    @(negedge clk);
    clear = 0;
    msg_valid = 0;
    msg_last = 0;
    chk1("clr_load_ready", msg_ready, 1'b1);
    chk1("clr_load_valid", win_valid, 1'b0);
    chk("clr_load_seg", win_seg, 32'hFFFFFFFF);
    gen(2);
    load(1);
    scroll(2);
    do_clear();
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(2, ML);
      gen(n);
      load(n == ML ? 1'($urandom_range(0, 1)) : 1'b1);
      scroll($urandom_range(1, 2 * n));
      repeat ($urandom_range(3, 12)) @(negedge clk);
      scroll($urandom_range(1, n));
      chk("rand_win", win_seg, win_of(moff));
      do_clear();
    end
    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_total", 32'(wrap_cnt), 32'(exp_wraps));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
